lfsr_prbs_gen_chk: RTL

Parametrised PRBS engine: one generator plus one self-synchronising checker, both producing or consuming OUT_W bits per clock.
- Polynomial is selected by DW; feedback is XNOR, shifting toward the MSB with the new bit entering at the LSB.
- Sits between the link/test logic and a SerDes or loopback path for BER measurement.
- Generator uses a valid/ready handshake; checker provides a lock FSM and a saturating error counter.

---
 rtl/lfsr_prbs_gen_chk.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_prbs_gen_chk.sv
// PRBS generator plus self-synchronising checker (XNOR LFSR, shift toward MSB, DW selects polynomial).
// Define LFSR_ERR_INJECT_EN to enable one-shot error injection on the generator output MSB.

module lfsr_prbs_gen_chk #(
    parameter int DW         = 7,
    parameter int OUT_W      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic             i_sysclk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [DW-1:0]    i_seed,
    output logic [OUT_W-1:0] o_gen_data,
    output logic             o_gen_valid,
    input  logic             i_gen_ready,
    input  logic [OUT_W-1:0] i_chk_data,
    input  logic             i_chk_valid,
    input  logic             i_cnt_clr,
    input  logic             i_inject,
    output logic             o_locked,
    output logic             o_beat_err,
    output logic [31:0]      o_err_cnt,
    output logic             o_seed_fix
);

    localparam int TAP_B = (DW == 7)  ? 6  :
                           (DW == 9)  ? 5  :
                           (DW == 15) ? 14 :
                           (DW == 23) ? 18 :
                           (DW == 31) ? 28 : 1;
    localparam int POP_W = $clog2(OUT_W + 1);

    generate
        if (!(DW == 7 || DW == 9 || DW == 15 || DW == 23 || DW == 31)) begin : g_bad_dw
            $error("lfsr_prbs_gen_chk: unsupported DW=%0d", DW);
        end
        if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
            $error("lfsr_prbs_gen_chk: OUT_W=%0d out of range 1..32", OUT_W);
        end
        if (LOCK_CNT < 1 || LOCK_CNT > 255 || UNLOCK_CNT < 1 || UNLOCK_CNT > 255) begin : g_bad_cnt
            $error("lfsr_prbs_gen_chk: LOCK_CNT/UNLOCK_CNT out of range 1..255");
        end
    endgenerate

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // One beat of the generator: returns {output bits, next state}, earliest bit in the MSB.
    function automatic logic [OUT_W+DW-1:0] gen_beat(input logic [DW-1:0] start);
        logic [DW-1:0]    s;
        logic [OUT_W-1:0] bits;
        logic             fb;
        // NOTE: blocking assignments here chain OUT_W serial steps within a single cycle.
        s    = start;
        bits = '0;
        for (int k = 0; k < OUT_W; k++) begin
            fb                = ~(s[DW-1] ^ s[TAP_B-1]);
            bits[OUT_W-1-k]   = fb;
            s                 = {s[DW-2:0], fb};
        end
        return {bits, s};
    endfunction

    // One beat of the checker: the received bit, not the prediction, feeds the register.
    function automatic logic [OUT_W+DW-1:0] chk_beat(input logic [DW-1:0] start,
                                                     input logic [OUT_W-1:0] rx);
        logic [DW-1:0]    s;
        logic [OUT_W-1:0] errs;
        logic             pred;
        s    = start;
        errs = '0;
        for (int k = 0; k < OUT_W; k++) begin
            pred            = ~(s[DW-1] ^ s[TAP_B-1]);
            errs[OUT_W-1-k] = rx[OUT_W-1-k] ^ pred;
            s               = {s[DW-2:0], rx[OUT_W-1-k]};
        end
        return {errs, s};
    endfunction

    // ---------------- generator ----------------
    logic [DW-1:0]    gen_state;
    logic [OUT_W-1:0] gen_data;
    logic             gen_valid;
    logic             seed_fix;
    logic             seed_lockup;
    logic [DW-1:0]    seed_eff;
    logic [OUT_W-1:0] load_bits, adv_bits;
    logic [DW-1:0]    load_next, adv_next;
    logic             accept;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        seed_lockup            = &i_seed;
        seed_eff               = seed_lockup ? '0 : i_seed;
        {load_bits, load_next} = gen_beat(seed_eff);
        {adv_bits, adv_next}   = gen_beat(gen_state);
    end

    assign accept = gen_valid & i_gen_ready;

    // gen_state holds the LFSR state just after the beat currently presented on gen_data.
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            gen_state <= '0;
            gen_data  <= '0;
            gen_valid <= 1'b0;
            seed_fix  <= 1'b0;
        end else begin
            gen_valid <= 1'b1;
            seed_fix  <= i_load & seed_lockup;
            if (i_load) begin
                gen_state <= load_next;
                gen_data  <= load_bits;
            end else if (!gen_valid || accept) begin
                gen_state <= adv_next;
                gen_data  <= adv_bits;
            end
        end
    end

`ifdef LFSR_ERR_INJECT_EN
    logic inject_q;
    logic inject_armed;

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            inject_q     <= 1'b0;
            inject_armed <= 1'b0;
        end else begin
            inject_q     <= i_inject;
            inject_armed <= (inject_armed & ~accept) | (i_inject & ~inject_q);
        end
    end

    // Corrupts the presented beat only; the LFSR state is untouched.
    assign o_gen_data = gen_data ^ (OUT_W'(inject_armed) << (OUT_W - 1));
`else
    logic unused_inject;
    assign unused_inject = i_inject;
    assign o_gen_data    = gen_data;
`endif

    assign o_gen_valid = gen_valid;
    assign o_seed_fix  = seed_fix;

    // ---------------- checker ----------------
    chk_state_e       chk_state;
    logic [DW-1:0]    chk_reg, chk_next;
    logic [OUT_W-1:0] err_bits;
    logic [POP_W-1:0] err_pop;
    logic [7:0]       run_cnt, bad_cnt, run_inc, bad_inc;
    logic [31:0]      err_cnt;
    logic [32:0]      cnt_sum;
    logic             beat_bad;
    logic             cnt_add;
    logic             locked;
    logic             beat_err;

    always_comb begin
        {err_bits, chk_next} = chk_beat(chk_reg, i_chk_data);
        err_pop              = '0;
        for (int k = 0; k < OUT_W; k++) begin
            err_pop = err_pop + POP_W'(err_bits[k]);
        end
        beat_bad = |err_bits;
        cnt_add  = i_chk_valid && (chk_state == LOCKED);
        cnt_sum  = {1'b0, err_cnt} + 33'(err_pop);
        run_inc  = run_cnt + 8'd1;
        bad_inc  = bad_cnt + 8'd1;
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            chk_state <= HUNT;
            chk_reg   <= '0;
            run_cnt   <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            beat_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (i_chk_valid) begin
                chk_reg  <= chk_next;
                beat_err <= beat_bad;
                case (chk_state)
                    HUNT: begin
                        if (beat_bad) begin
                            run_cnt <= '0;
                        end else if (run_inc == 8'(LOCK_CNT)) begin
                            chk_state <= LOCKED;
                            locked    <= 1'b1;
                            run_cnt   <= '0;
                            bad_cnt   <= '0;
                        end else begin
                            run_cnt <= run_inc;
                        end
                    end
                    LOCKED: begin
                        if (!beat_bad) begin
                            bad_cnt <= '0;
                        end else if (bad_inc == 8'(UNLOCK_CNT)) begin
                            chk_state <= HUNT;
                            locked    <= 1'b0;
                            run_cnt   <= '0;
                            bad_cnt   <= '0;
                        end else begin
                            bad_cnt <= bad_inc;
                        end
                    end
                    default: begin
                        chk_state <= HUNT;
                        locked    <= 1'b0;
                    end
                endcase
            end
            // A clear coinciding with a counted beat leaves just that beat's errors.
            if (i_cnt_clr) begin
                err_cnt <= cnt_add ? 32'(err_pop) : 32'd0;
            end else if (cnt_add) begin
                err_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
            end
        end
    end

    assign o_locked   = locked;
    assign o_beat_err = beat_err;
    assign o_err_cnt  = err_cnt;

endmodule
